period_meter: RTL

- Receive-side counterpart of the sampling clock counter: measures the interval, in clk cycles, between successive pulses on a sample strobe.
- Each measurement is returned on a val/rdy stream.
- Used to confirm the programmed sampling period and to measure external sample strobes on the SPI side.
- Enable is written through a val/rdy config port, matching the counter block's config style.

---
 rtl/period_meter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/period_meter.sv
// period_meter: measures the interval, in clk cycles, between successive
// single-cycle pulses on strobe and returns each measurement on a val/rdy
// stream through a one-deep output register.
// Enable/restart is written through a val/rdy config port (always ready
// outside reset).
// Optional feature macro: PERIOD_METER_SATURATE_EN
//   defined   -> the interval counter saturates at 2^nbits-1 and sets the
//                sticky overflow flag
//   undefined -> the interval counter wraps modulo 2^nbits, overflow tied to 0
module period_meter #(
  parameter int unsigned nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic             en_msg,
  input  logic             en_val,
  output logic             en_rdy,
  output logic [nbits-1:0] period_msg,
  output logic             period_val,
  input  logic             period_rdy,
  output logic             overflow,
  output logic             missed
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [nbits-1:0] CNT_ONE = {{(nbits-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [nbits-1:0] cnt_q;
  logic [nbits-1:0] period_msg_q;
  logic             period_val_q;
  logic             missed_q;
  logic             cfg_wr;
  logic             consume;
`ifdef PERIOD_METER_SATURATE_EN
  logic             overflow_q;
`endif

  // Config port accepts every cycle except while reset is held
  always_comb begin
    en_rdy  = ~reset;
    cfg_wr  = en_val & ~reset;
    consume = period_val_q & period_rdy;
  end

  // Measurement FSM, interval counter, output register and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_msg_q <= '0;
      period_val_q <= 1'b0;
      missed_q     <= 1'b0;
`ifdef PERIOD_METER_SATURATE_EN
      overflow_q   <= 1'b0;
`endif
    end else begin
      // A consumed word empties the register unless a new result loads below
      if (consume) begin
        period_val_q <= 1'b0;
      end
      if (cfg_wr) begin
        // Config write wins over a coincident strobe; pending word is kept
        cnt_q <= '0;
        if (en_msg) begin
          state_q  <= ARM;
          missed_q <= 1'b0;
`ifdef PERIOD_METER_SATURATE_EN
          overflow_q <= 1'b0;
`endif
        end else begin
          state_q <= IDLE;
        end
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
          end
          ARM: begin
            if (strobe) begin
              state_q <= MEASURE;
              cnt_q   <= CNT_ONE;
            end
          end
          MEASURE: begin
            if (strobe) begin
              cnt_q <= CNT_ONE;
              if (period_val_q && !period_rdy) begin
                missed_q <= 1'b1;
              end else begin
                period_msg_q <= cnt_q;
                period_val_q <= 1'b1;
              end
            end else begin
`ifdef PERIOD_METER_SATURATE_EN
              if (cnt_q == '1) begin
                overflow_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
`else
              cnt_q <= cnt_q + CNT_ONE;
`endif
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign period_msg = period_msg_q;
  assign period_val = period_val_q;
  assign missed     = missed_q;
`ifdef PERIOD_METER_SATURATE_EN
  assign overflow   = overflow_q;
`else
  assign overflow   = 1'b0;
`endif

endmodule
